// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: one-in-flight arbiter between fetch, load and store
// requesters and a byte-serial memory controller, with flush draining.
module mem_req_arbiter #(
   parameter int XLEN           = 32,
   parameter int ROB_SIZE_WIDTH = 5,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      if_req,
   input  logic [XLEN-1:0]           if_addr,
   input  logic                      ld_req,
   input  logic [XLEN-1:0]           ld_addr,
   input  logic [1:0]                ld_size,
   input  logic                      ld_signed,
   input  logic [ROB_SIZE_WIDTH-1:0] ld_id,
   input  logic                      st_req,
   input  logic [XLEN-1:0]           st_addr,
   input  logic [1:0]                st_size,
   input  logic [XLEN-1:0]           st_data,
   output logic                      if_gnt,
   output logic                      ld_gnt,
   output logic                      st_gnt,
   output logic                      if_resp_valid,
   output logic [XLEN-1:0]           if_resp_inst,
   output logic [XLEN-1:0]           if_resp_addr,
   output logic                      ld_resp_valid,
   output logic [XLEN-1:0]           ld_resp_data,
   output logic [ROB_SIZE_WIDTH-1:0] ld_resp_id,
   output logic                      mc_req_valid,
   output logic                      mc_req_wr,
   output logic [XLEN-1:0]           mc_req_addr,
   output logic [1:0]                mc_req_size,
   output logic [XLEN-1:0]           mc_req_wdata,
   input  logic                      mc_busy,
   input  logic                      mc_done,
   input  logic [XLEN-1:0]           mc_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
   typedef enum logic [1:0] {K_IF, K_LD, K_ST} kind_t;

   state_t                    state_q, state_d;
   kind_t                     kind_q, kind_d;
   logic [SW-1:0]             streak_q, streak_d;
   logic                      last_data_q, last_data_d;
   logic                      acc_q, acc_d;
   logic [XLEN-1:0]           addr_q, addr_d;
   logic [1:0]                size_q, size_d;
   logic [XLEN-1:0]           wdata_q, wdata_d;
   logic                      wr_q, wr_d;
   logic                      sgn_q, sgn_d;
   logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
   logic                      mc_valid_q, mc_valid_d;
   logic                      if_gnt_q, if_gnt_d;
   logic                      ld_gnt_q, ld_gnt_d;
   logic                      st_gnt_q, st_gnt_d;
   logic                      if_rv_q, if_rv_d;
   logic [XLEN-1:0]           if_inst_q, if_inst_d;
   logic [XLEN-1:0]           if_raddr_q, if_raddr_d;
   logic                      ld_rv_q, ld_rv_d;
   logic [XLEN-1:0]           ld_data_q, ld_data_d;
   logic [ROB_SIZE_WIDTH-1:0] ld_rid_q, ld_rid_d;

   logic                      win_st, win_if, win_ld;
   logic                      cancel;
   logic [SW-1:0]             streak_inc;
   logic [XLEN-1:0]           ld_ext;

   always_comb begin
      ld_ext = mc_rdata;
      unique case (size_q)
         2'b00:   ld_ext = {{(XLEN-8){sgn_q & mc_rdata[7]}},
                            mc_rdata[7:0]};
         2'b01:   ld_ext = {{(XLEN-16){sgn_q & mc_rdata[15]}},
                            mc_rdata[15:0]};
         default: ld_ext = mc_rdata;
      endcase
   end

   // Fetch wins a tie after a data grant or once data has hit the streak cap.
   assign win_st = st_req;
   assign win_if = !st_req && if_req &&
                   (!ld_req || last_data_q ||
                    streak_q == SW'(STARVE_LIMIT));
   assign win_ld = !st_req && ld_req && !win_if;
   assign cancel = flush && (kind_q != K_ST);
   assign streak_inc = (streak_q == SW'(STARVE_LIMIT)) ?
                       streak_q : streak_q + SW'(1);

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      streak_d    = streak_q;
      last_data_d = last_data_q;
      acc_d       = acc_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      sgn_d       = sgn_q;
      id_d        = id_q;
      mc_valid_d  = mc_valid_q;
      if_gnt_d    = if_gnt_q;
      ld_gnt_d    = ld_gnt_q;
      st_gnt_d    = st_gnt_q;
      if_rv_d     = if_rv_q;
      if_inst_d   = if_inst_q;
      if_raddr_d  = if_raddr_q;
      ld_rv_d     = ld_rv_q;
      ld_data_d   = ld_data_q;
      ld_rid_d    = ld_rid_q;
      if (rdy) begin
         if_gnt_d = 1'b0;
         ld_gnt_d = 1'b0;
         st_gnt_d = 1'b0;
         if_rv_d  = 1'b0;
         ld_rv_d  = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!flush) begin
                  unique case (1'b1)
                     win_st: begin
                        st_gnt_d    = 1'b1;
                        kind_d      = K_ST;
                        addr_d      = st_addr;
                        size_d      = st_size;
                        wdata_d     = st_data;
                        wr_d        = 1'b1;
                        streak_d    = streak_inc;
                        last_data_d = 1'b1;
                        mc_valid_d  = 1'b1;
                        state_d     = ISSUE;
                     end
                     win_if: begin
                        if_gnt_d    = 1'b1;
                        kind_d      = K_IF;
                        addr_d      = if_addr;
                        size_d      = 2'b10;
                        wdata_d     = '0;
                        wr_d        = 1'b0;
                        streak_d    = '0;
                        last_data_d = 1'b0;
                        mc_valid_d  = 1'b1;
                        state_d     = ISSUE;
                     end
                     win_ld: begin
                        ld_gnt_d    = 1'b1;
                        kind_d      = K_LD;
                        addr_d      = ld_addr;
                        size_d      = ld_size;
                        sgn_d       = ld_signed;
                        id_d        = ld_id;
                        wdata_d     = '0;
                        wr_d        = 1'b0;
                        streak_d    = streak_inc;
                        last_data_d = 1'b1;
                        mc_valid_d  = 1'b1;
                        state_d     = ISSUE;
                     end
                     default: ;
                  endcase
               end
            end
            ISSUE: begin
               if (!mc_busy) begin
                  mc_valid_d = 1'b0;
                  acc_d      = 1'b1;
                  state_d    = cancel ? DRAIN : WAIT;
               end else if (cancel) begin
                  mc_valid_d = 1'b0;
                  acc_d      = 1'b0;
                  state_d    = DRAIN;
               end
            end
            WAIT: begin
               if (mc_done) begin
                  state_d = IDLE;
                  if (!flush && kind_q == K_IF) begin
                     if_rv_d    = 1'b1;
                     if_inst_d  = mc_rdata;
                     if_raddr_d = addr_q;
                  end
                  if (!flush && kind_q == K_LD) begin
                     ld_rv_d   = 1'b1;
                     ld_data_d = ld_ext;
                     ld_rid_d  = id_q;
                  end
               end else if (cancel) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (!acc_q || mc_done) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         kind_q      <= K_IF;
         streak_q    <= '0;
         last_data_q <= 1'b1;
         acc_q       <= 1'b0;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         sgn_q       <= 1'b0;
         id_q        <= '0;
         mc_valid_q  <= 1'b0;
         if_gnt_q    <= 1'b0;
         ld_gnt_q    <= 1'b0;
         st_gnt_q    <= 1'b0;
         if_rv_q     <= 1'b0;
         if_inst_q   <= '0;
         if_raddr_q  <= '0;
         ld_rv_q     <= 1'b0;
         ld_data_q   <= '0;
         ld_rid_q    <= '0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         streak_q    <= streak_d;
         last_data_q <= last_data_d;
         acc_q       <= acc_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         sgn_q       <= sgn_d;
         id_q        <= id_d;
         mc_valid_q  <= mc_valid_d;
         if_gnt_q    <= if_gnt_d;
         ld_gnt_q    <= ld_gnt_d;
         st_gnt_q    <= st_gnt_d;
         if_rv_q     <= if_rv_d;
         if_inst_q   <= if_inst_d;
         if_raddr_q  <= if_raddr_d;
         ld_rv_q     <= ld_rv_d;
         ld_data_q   <= ld_data_d;
         ld_rid_q    <= ld_rid_d;
      end
   end

   assign if_gnt        = if_gnt_q;
   assign ld_gnt        = ld_gnt_q;
   assign st_gnt        = st_gnt_q;
   assign if_resp_valid = if_rv_q;
   assign if_resp_inst  = if_inst_q;
   assign if_resp_addr  = if_raddr_q;
   assign ld_resp_valid = ld_rv_q;
   assign ld_resp_data  = ld_data_q;
   assign ld_resp_id    = ld_rid_q;
   assign mc_req_valid  = mc_valid_q;
   assign mc_req_wr     = wr_q;
   assign mc_req_addr   = addr_q;
   assign mc_req_size   = size_q;
   assign mc_req_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: random + directed stimulus against a queue-based
// reference model; responses are checked by an independent monitor.
module tb_mem_req_arbiter;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst_n, rdy, flush;
   logic if_req, ld_req, ld_signed, st_req;
   logic [31:0] if_addr, ld_addr, st_addr, st_data;
   logic [1:0] ld_size, st_size;
   logic [4:0] ld_id;
   logic if_gnt, ld_gnt, st_gnt;
   logic if_resp_valid, ld_resp_valid;
   logic [31:0] if_resp_inst, if_resp_addr, ld_resp_data;
   logic [4:0] ld_resp_id;
   logic mc_req_valid, mc_req_wr;
   logic [31:0] mc_req_addr, mc_req_wdata;
   logic [1:0] mc_req_size;
   logic mc_busy, mc_done;
   logic [31:0] mc_rdata;

   mem_req_arbiter #(.XLEN(32), .ROB_SIZE_WIDTH(5),
                     .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
      .if_req(if_req), .if_addr(if_addr),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_signed(ld_signed), .ld_id(ld_id),
      .st_req(st_req), .st_addr(st_addr), .st_size(st_size),
      .st_data(st_data),
      .if_gnt(if_gnt), .ld_gnt(ld_gnt), .st_gnt(st_gnt),
      .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
      .if_resp_addr(if_resp_addr),
      .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
      .ld_resp_id(ld_resp_id),
      .mc_req_valid(mc_req_valid), .mc_req_wr(mc_req_wr),
      .mc_req_addr(mc_req_addr), .mc_req_size(mc_req_size),
      .mc_req_wdata(mc_req_wdata),
      .mc_busy(mc_busy), .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // reference model state
   int  streak = 0;
   bit  last_data = 1'b1;
   bit  outstanding = 1'b0;
   int  glog[$];
   logic [63:0] q_if[$];
   logic [63:0] q_ld[$];
   logic [31:0] ex_addr, ex_wdata;
   logic [1:0]  ex_size;
   logic        ex_wr;

   // controller model state
   bit c_wait = 1'b0;
   int c_cnt = 0;
   bit prev_valid = 1'b0;
   bit busy_prev = 1'b0;
   logic [31:0] prev_addr, prev_wdata, c_addr;
   logic [1:0]  prev_size, c_size;
   logic        prev_wr, c_wr;

   int  rr_if = 0, rr_ld = 0, rr_st = 0;
   bit  rand_en = 1'b0;
   int  idle_cnt = 0;
   logic [31:0] last_ld_data = '0;
   logic [4:0]  last_ld_id = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h100: return 8'h80;
         32'h200: return 8'h01;
         32'h201: return 8'h80;
         32'h300: return 8'hEF;
         32'h301: return 8'hBE;
         32'h302: return 8'hAD;
         32'h303: return 8'hDE;
         default: begin
            h = a * 32'h9E3779B1;
            return h[31:24];
         end
      endcase
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a,
                                            input logic [1:0] sz);
      logic [31:0] v = '0;
      for (int i = 0; i < nbytes(sz); i++)
         v[8*i +: 8] = mem_byte(a + 32'(i));
      return v;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a,
                                            input logic [1:0] sz,
                                            input logic sgn);
      longint raw;
      int nb;
      nb = nbytes(sz);
      raw = longint'(mem_read(a, sz));
      if (sgn && nb < 4 && raw >= (longint'(1) << (8*nb - 1)))
         raw = raw - (longint'(1) << (8*nb));
      return raw[31:0];
   endfunction

   function automatic int model_winner();
      if (st_req) return 2;
      if (if_req && !ld_req) return 0;
      if (ld_req && !if_req) return 1;
      if (if_req && ld_req)
         return (streak == LIM || last_data) ? 0 : 1;
      return -1;
   endfunction

   task automatic set_if(input logic [31:0] a);
      if_req = 1'b1; if_addr = a;
   endtask

   task automatic set_ld(input logic [31:0] a, input logic [1:0] sz,
                         input logic sgn, input logic [4:0] id);
      ld_req = 1'b1; ld_addr = a; ld_size = sz;
      ld_signed = sgn; ld_id = id;
   endtask

   task automatic set_st(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d);
      st_req = 1'b1; st_addr = a; st_size = sz; st_data = d;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return 32'h100;
         1: return 32'h200;
         2: return 32'h300;
         default: return $urandom;
      endcase
   endfunction

   // One cycle of the automatic environment, run 1 time unit after posedge.
   task automatic auto_step();
      int ng, w, g;
      ng = int'(if_gnt) + int'(ld_gnt) + int'(st_gnt);
      if (ng != 0) begin
         w = model_winner();
         g = st_gnt ? 2 : (ld_gnt ? 1 : 0);
         chk("grant_kind", 32'(g), 32'(w));
         chk("grant_legal", 32'(ng == 1 && !outstanding), 32'd1);
         glog.push_back(g);
         if (g == 0) begin
            streak = 0; last_data = 1'b0;
         end else begin
            streak = (streak < LIM) ? streak + 1 : LIM;
            last_data = 1'b1;
         end
         outstanding = 1'b1;
         idle_cnt = 0;
         case (g)
            0: begin
               ex_addr = if_addr; ex_size = 2'b10; ex_wr = 1'b0;
               q_if.push_back({mem_read(if_addr, 2'b10), if_addr});
               if_req = 1'b0;
               if (rr_if > 0) begin
                  rr_if--; set_if(if_addr + 32'd4);
               end
            end
            1: begin
               ex_addr = ld_addr; ex_size = ld_size; ex_wr = 1'b0;
               q_ld.push_back({ref_load(ld_addr, ld_size, ld_signed),
                               27'd0, ld_id});
               ld_req = 1'b0;
               if (rr_ld > 0) begin
                  rr_ld--; set_ld(rand_addr(), 2'($urandom_range(0, 3)),
                                  1'($urandom), 5'($urandom));
               end
            end
            default: begin
               ex_addr = st_addr; ex_size = st_size; ex_wr = 1'b1;
               ex_wdata = st_data;
               st_req = 1'b0;
               if (rr_st > 0) begin
                  rr_st--; set_st($urandom, 2'($urandom_range(0, 2)),
                                  $urandom);
               end
            end
         endcase
      end
      if (mc_done) begin
         outstanding = 1'b0;
         mc_done = 1'b0;
      end
      if (prev_valid && !busy_prev) begin
         chk("mc_addr", prev_addr, ex_addr);
         chk("mc_size", 32'(prev_size), 32'(ex_size));
         chk("mc_wr", 32'(prev_wr), 32'(ex_wr));
         if (ex_wr) chk("mc_wdata", prev_wdata, ex_wdata);
         chk("mc_valid_drop", 32'(mc_req_valid), 32'd0);
         c_wait = 1'b1;
         c_cnt = $urandom_range(0, 3);
         c_addr = prev_addr; c_size = prev_size; c_wr = prev_wr;
      end
      mc_rdata = $urandom;
      if (c_wait) begin
         if (c_cnt == 0) begin
            mc_done = 1'b1;
            if (!c_wr) mc_rdata = mem_read(c_addr, c_size);
            c_wait = 1'b0;
         end else begin
            c_cnt--;
         end
      end
      mc_busy = ($urandom_range(0, 2) == 0);
      prev_valid = mc_req_valid;
      busy_prev = mc_busy;
      prev_addr = mc_req_addr;
      prev_size = mc_req_size;
      prev_wr = mc_req_wr;
      prev_wdata = mc_req_wdata;
      if ((if_req || ld_req || st_req) && !outstanding) begin
         idle_cnt++;
         if (idle_cnt > 20) begin
            checks++;
            $display("FAIL grant_timeout: waited %0d cycles want <= 20",
                     idle_cnt);
            if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
            idle_cnt = 0;
         end
      end
      if (rand_en) begin
         if (!if_req && $urandom_range(0, 3) == 0)
            set_if($urandom & 32'hFFFF_FFFC);
         if (!ld_req && $urandom_range(0, 3) == 0)
            set_ld(rand_addr(), 2'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom));
         if (!st_req && $urandom_range(0, 5) == 0)
            set_st($urandom, 2'($urandom_range(0, 3)), $urandom);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      auto_step();
   endtask

   task automatic quiesce();
      int n = 0;
      while ((if_req || ld_req || st_req || outstanding) && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) begin
         checks++;
         $display("FAIL quiesce_timeout: still busy after %0d cycles", n);
      end
      repeat (2) step();
   endtask

   // response monitor
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n) begin
         if (if_resp_valid) begin
            if (q_if.size() == 0) begin
               checks++;
               $display("FAIL if_resp_unexpected: got addr %h want none",
                        if_resp_addr);
            end else begin
               e = q_if.pop_front();
               chk("if_resp_inst", if_resp_inst, e[63:32]);
               chk("if_resp_addr", if_resp_addr, e[31:0]);
            end
         end
         if (ld_resp_valid) begin
            last_ld_data <= ld_resp_data;
            last_ld_id <= ld_resp_id;
            if (q_ld.size() == 0) begin
               checks++;
               $display("FAIL ld_resp_unexpected: got %h want none",
                        ld_resp_data);
            end else begin
               e = q_ld.pop_front();
               chk("ld_resp_data", ld_resp_data, e[63:32]);
               chk("ld_resp_id", 32'(ld_resp_id), 32'(e[4:0]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;
      if_req = 0; ld_req = 0; st_req = 0;
      if_addr = 0; ld_addr = 0; ld_size = 0; ld_signed = 0; ld_id = 0;
      st_addr = 0; st_size = 0; st_data = 0;
      mc_busy = 0; mc_done = 0; mc_rdata = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_gnts", {29'd0, if_gnt, ld_gnt, st_gnt}, 32'd0);
      chk("rst_resp_valid", {30'd0, if_resp_valid, ld_resp_valid}, 32'd0);
      chk("rst_mc_valid", 32'(mc_req_valid), 32'd0);
      chk("rst_mc_addr", mc_req_addr, 32'd0);
      chk("rst_ld_data", ld_resp_data, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // tie right after reset: last winner is data, so fetch goes first
      step();
      set_if(32'h40); set_ld(32'h300, 2'b10, 1'b0, 5'd1);
      quiesce();
      chk("rst_tie_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
      chk("rst_tie_second", 32'(glog.size() > 1 ? glog[1] : -1), 32'd1);

      glog.delete();
      set_st(32'h500, 2'b10, 32'h11223344);
      set_ld(32'h200, 2'b01, 1'b1, 5'd2);
      set_if(32'h80);
      quiesce();
      chk("prio_len", 32'(glog.size()), 32'd3);
      for (int i = 0; i < 3 && i < glog.size(); i++)
         chk("prio_order", 32'(glog[i]), (i == 0) ? 32'd2 :
                                         (i == 1) ? 32'd0 : 32'd1);

      glog.delete();
      set_if(32'hC0);
      set_st(32'h600, 2'b00, 32'hA5);
      rr_st = 3;
      quiesce();
      chk("starve_len", 32'(glog.size()), 32'd5);
      for (int i = 0; i < 5 && i < glog.size(); i++)
         chk("starve_order", 32'(glog[i]), (i < 4) ? 32'd2 : 32'd0);

      glog.delete();
      set_if(32'h100); set_ld(32'h300, 2'b10, 1'b0, 5'd4);
      rr_if = 2; rr_ld = 2;
      quiesce();
      chk("alt_len", 32'(glog.size()), 32'd6);
      for (int i = 0; i < 6 && i < glog.size(); i++)
         chk("alt_order", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

      set_ld(32'h100, 2'b00, 1'b1, 5'd7);
      quiesce();
      chk("ld_byte_sext", last_ld_data, 32'hFFFF_FF80);
      chk("ld_byte_id", 32'(last_ld_id), 32'd7);
      set_ld(32'h200, 2'b01, 1'b0, 5'd3);
      quiesce();
      chk("ld_half_zext", last_ld_data, 32'h0000_8001);
      set_ld(32'h300, 2'b10, 1'b1, 5'd21);
      quiesce();
      chk("ld_word", last_ld_data, 32'hDEAD_BEEF);
      chk("ld_word_id", 32'(last_ld_id), 32'd21);

      rand_en = 1'b1;
      repeat (3000) step();
      rand_en = 1'b0;
      quiesce();

      // flush a fetch while it waits on the controller
      mc_busy = 0; mc_done = 0;
      @(negedge clk);
      set_if(32'h1000);
      @(negedge clk);
      chk("fl_if_gnt", 32'(if_gnt), 32'd1);
      chk("fl_mc_valid", 32'(mc_req_valid), 32'd1);
      if_req = 0;
      @(negedge clk);
      chk("fl_accepted", 32'(mc_req_valid), 32'd0);
      flush = 1;
      @(negedge clk);
      flush = 0;
      set_if(32'h2000);
      mc_done = 1; mc_rdata = 32'h1357_9BDF;
      @(negedge clk);
      mc_done = 0;
      chk("fl_no_resp", 32'(if_resp_valid), 32'd0);
      chk("fl_no_gnt_drain", 32'(if_gnt), 32'd0);
      @(negedge clk);
      chk("fl_gnt_after_idle", 32'(if_gnt), 32'd1);
      if_req = 0;
      q_if.push_back({32'h0BAD_F00D, 32'h2000});
      @(negedge clk);
      mc_done = 1; mc_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      mc_done = 0;
      chk("fl_resp_after", 32'(if_resp_valid), 32'd1);

      // flush cannot cancel a store stuck behind a busy controller
      mc_busy = 1;
      set_st(32'h4000, 2'b10, 32'hCAFE_F00D);
      @(negedge clk);
      chk("st_gnt", 32'(st_gnt), 32'd1);
      st_req = 0; flush = 1;
      @(negedge clk);
      flush = 0;
      chk("st_flush_valid_held", 32'(mc_req_valid), 32'd1);
      @(negedge clk);
      chk("st_busy_valid_held", 32'(mc_req_valid), 32'd1);
      mc_busy = 0;
      @(negedge clk);
      chk("st_accepted", 32'(mc_req_valid), 32'd0);
      chk("st_wdata", mc_req_wdata, 32'hCAFE_F00D);
      mc_done = 1; mc_rdata = 32'h0;
      @(negedge clk);
      mc_done = 0;
      set_ld(32'h300, 2'b10, 1'b0, 5'd9);
      q_ld.push_back({32'hDEAD_BEEF, 27'd0, 5'd9});
      @(negedge clk);
      chk("st_then_ld_gnt", 32'(ld_gnt), 32'd1);
      ld_req = 0; rdy = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rdy_gnt_frozen", 32'(ld_gnt), 32'd1);
         chk("rdy_valid_frozen", 32'(mc_req_valid), 32'd1);
      end
      rdy = 1;
      @(negedge clk);
      chk("rdy_resume", 32'(mc_req_valid), 32'd0);
      rdy = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rdy_wait_frozen", {30'd0, mc_req_valid, ld_resp_valid},
             32'd0);
         chk("rdy_wait_addr", mc_req_addr, 32'h300);
      end
      rdy = 1; mc_done = 1; mc_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mc_done = 0;
      chk("rdy_ld_resp", 32'(ld_resp_valid), 32'd1);

      // asynchronous reset with a load outstanding
      set_ld(32'h100, 2'b00, 1'b1, 5'd3);
      @(negedge clk);
      chk("rw_gnt", 32'(ld_gnt), 32'd1);
      ld_req = 0;
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("rw_async_addr", mc_req_addr, 32'd0);
      chk("rw_async_flags", {27'd0, if_gnt, ld_gnt, st_gnt, mc_req_valid,
                             ld_resp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1; mc_done = 1; mc_rdata = 32'h80;
      @(negedge clk);
      mc_done = 0;
      @(negedge clk);
      chk("rw_no_resp", 32'(ld_resp_valid), 32'd0);
      set_if(32'h3000);
      @(negedge clk);
      chk("rw_idle_gnt", 32'(if_gnt), 32'd1);
      if_req = 0;
      @(negedge clk);

      chk("q_if_empty", 32'(q_if.size()), 32'd0);
      chk("q_ld_empty", 32'(q_ld.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
